// File: rtl/comp_conv_pipe.sv
// comp_conv_pipe: 2-stage streaming sign-magnitude <-> two's-complement converter
// with valid/ready backpressure, unrepresentable-case flags and a saturating ovf counter.
module comp_conv_pipe #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_ovf,
    output logic          out_negz,
    output logic [CW-1:0] ovf_cnt
);
    logic         s1_v;
    logic         s1_mode;
    logic [W-1:0] s1_d;
    logic         s1_adv;
    logic         s2_adv;
    logic         sign;
    logic         zmag;
    logic [W-2:0] mag;
    logic [W-2:0] neg;
    logic [W-1:0] conv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;

    // Both directions negate the low W-1 bits; only the zero-magnitude case differs.
    always_comb begin
        sign = s1_d[W-1];
        mag  = s1_d[W-2:0];
        zmag = mag == '0;
        neg  = ~mag + (W-1)'(1);
        conv = !sign ? s1_d : zmag ? (s1_mode ? '1 : '0) : {1'b1, neg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_mode <= 1'b0;
            s1_d    <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_d    <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_negz  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_data <= conv;
                out_ovf  <= s1_mode && sign && zmag;
                out_negz <= !s1_mode && sign && zmag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_cnt <= '0;
        else if (out_valid && out_ready && out_ovf && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + CW'(1);
    end
endmodule
